// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I core; drives the ALU, operand muxes and write enables.
// Build option: MULTICYCLE_CTRL_BNE_EN lets the BEQ state also resolve bne (funct3 = 001).
module multicycle_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pcwrite,
    output logic       adrsrc,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] immsrc,
    output logic [2:0] alucontrol,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BEQ, S_ILLEGAL
    } state_t;

    typedef enum logic [1:0] {
        AOP_ADD   = 2'b00,
        AOP_SUB   = 2'b01,
        AOP_FUNCT = 2'b10
    } aluop_t;

    typedef struct packed {
        logic       adrsrc;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic [1:0] resultsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        aluop_t     aluop;
        logic       pcupdate;
        logic       branch;
        logic       illegal;
    } ctrl_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    // Control word is registered alongside the state, so it always reflects the current state.
    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.irwrite   = 1'b1;
                c.alusrcb   = 2'b10;
                c.resultsrc = 2'b10;
                c.pcupdate  = 1'b1;
            end
            S_DECODE: begin
                c.alusrca = 2'b01;
                c.alusrcb = 2'b01;
            end
            S_MEMADR: begin
                c.alusrca = 2'b10;
                c.alusrcb = 2'b01;
            end
            S_MEMREAD:  c.adrsrc = 1'b1;
            S_MEMWB: begin
                c.resultsrc = 2'b01;
                c.regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adrsrc   = 1'b1;
                c.memwrite = 1'b1;
            end
            S_EXECR: begin
                c.alusrca = 2'b10;
                c.aluop   = AOP_FUNCT;
            end
            S_EXECI: begin
                c.alusrca = 2'b10;
                c.alusrcb = 2'b01;
                c.aluop   = AOP_FUNCT;
            end
            S_ALUWB:    c.regwrite = 1'b1;
            S_JAL: begin
                c.alusrca  = 2'b01;
                c.alusrcb  = 2'b10;
                c.pcupdate = 1'b1;
            end
            S_BEQ: begin
                c.alusrca = 2'b10;
                c.aluop   = AOP_SUB;
                c.branch  = 1'b1;
            end
            S_ILLEGAL:  c.illegal = 1'b1;
            default:    c = '0;
        endcase
        return c;
    endfunction

    state_t r_state;
    state_t w_next;
    ctrl_t  r_ctrl;
    logic   w_taken;

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
                    OP_I:         w_next = S_EXECI;
                    OP_JAL:       w_next = S_JAL;
                    OP_BEQ:       w_next = S_BEQ;
                    default:      w_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = S_FETCH;
            S_EXECR:    w_next = S_ALUWB;
            S_EXECI:    w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            S_BEQ:      w_next = S_FETCH;
            S_ILLEGAL:  w_next = S_ILLEGAL;
            default:    w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
            r_ctrl  <= ctrl_for(S_FETCH);
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrl_for(w_next);
        end
    end

`ifdef MULTICYCLE_CTRL_BNE_EN
    assign w_taken = zero ^ funct3[0];
`else
    assign w_taken = zero;
`endif

    // Enables are gated by reset_n so nothing is written while reset is held.
    assign pcwrite   = reset_n & (r_ctrl.pcupdate | (r_ctrl.branch & w_taken));
    assign memwrite  = reset_n & r_ctrl.memwrite;
    assign irwrite   = reset_n & r_ctrl.irwrite;
    assign regwrite  = reset_n & r_ctrl.regwrite;
    assign illegal   = reset_n & r_ctrl.illegal;
    assign adrsrc    = r_ctrl.adrsrc;
    assign resultsrc = r_ctrl.resultsrc;
    assign alusrca   = r_ctrl.alusrca;
    assign alusrcb   = r_ctrl.alusrcb;

    always_comb begin
        immsrc = 2'b00;
        case (op)
            OP_SW:   immsrc = 2'b01;
            OP_BEQ:  immsrc = 2'b10;
            OP_JAL:  immsrc = 2'b11;
            default: immsrc = 2'b00;
        endcase
    end

    always_comb begin
        alucontrol = 3'b010;
        case (r_ctrl.aluop)
            AOP_ADD: alucontrol = 3'b010;
            AOP_SUB: alucontrol = 3'b110;
            AOP_FUNCT: begin
                case (funct3)
                    3'b000:  alucontrol = (funct7b5 & op[5]) ? 3'b110 : 3'b010;
                    3'b010:  alucontrol = 3'b111;
                    3'b110:  alucontrol = 3'b001;
                    3'b111:  alucontrol = 3'b000;
                    default: alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed instructions, random instruction stream,
// illegal-opcode lockup and reset recovery, checked against a per-instruction cycle model.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
    logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
    logic [2:0] alucontrol;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IA  = 7'b0010011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    localparam logic [16:0] ALU_MASK = 17'h1FFF1;
    localparam logic [16:0] ALL_MASK = 17'h1FFFF;

    multicycle_controller dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .pcwrite(pcwrite), .adrsrc(adrsrc), .memwrite(memwrite),
        .irwrite(irwrite), .regwrite(regwrite), .resultsrc(resultsrc), .alusrca(alusrca),
        .alusrcb(alusrcb), .immsrc(immsrc), .alucontrol(alucontrol), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // {pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc, alusrca, alusrcb, immsrc, alucontrol, illegal}
    function automatic logic [16:0] obs();
        return {pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc, alusrca, alusrcb,
                immsrc, alucontrol, illegal};
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        if (o == SW)  return 2'b01;
        if (o == BR)  return 2'b10;
        if (o == JAL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [2:0] alu_funct(input logic [2:0] f3, input logic f7, input logic [6:0] o);
        if (f3 == 3'b000) return (f7 && o == RT) ? 3'b110 : 3'b010;
        if (f3 == 3'b010) return 3'b111;
        if (f3 == 3'b110) return 3'b001;
        if (f3 == 3'b111) return 3'b000;
        return 3'b010;
    endfunction

    function automatic int instr_len(input logic [6:0] o);
        if (o == LW) return 5;
        if (o == BR) return 3;
        if (o == SW || o == RT || o == IA || o == JAL) return 4;
        return 2;
    endfunction

    // Expected outputs for cycle k of an instruction; mask clears alucontrol where no ALU op is defined.
    task automatic model(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                         input int k, output logic [16:0] e, output logic [16:0] m);
        logic pc, adr, mw, ir, rw, ill;
        logic [1:0] rs, a, b;
        logic [2:0] alu;
        logic taken;
        pc = 0; adr = 0; mw = 0; ir = 0; rw = 0; ill = 0;
        rs = 2'b00; a = 2'b00; b = 2'b00; alu = 3'b010;
        m = ALL_MASK;
`ifdef MULTICYCLE_CTRL_BNE_EN
        taken = z ^ f3[0];
`else
        taken = z;
`endif
        if (k == 0) begin
            pc = 1; ir = 1; rs = 2'b10; b = 2'b10;
        end else if (k == 1) begin
            a = 2'b01; b = 2'b01;
        end else if (o == LW || o == SW) begin
            if (k == 2) begin a = 2'b10; b = 2'b01; end
            else if (o == SW) begin adr = 1; mw = 1; m = ALU_MASK; end
            else if (k == 3) begin adr = 1; m = ALU_MASK; end
            else begin rs = 2'b01; rw = 1; m = ALU_MASK; end
        end else if (o == RT || o == IA) begin
            if (k == 2) begin a = 2'b10; b = (o == IA) ? 2'b01 : 2'b00; alu = alu_funct(f3, f7, o); end
            else begin rw = 1; m = ALU_MASK; end
        end else if (o == JAL) begin
            if (k == 2) begin a = 2'b01; b = 2'b10; pc = 1; end
            else begin rw = 1; m = ALU_MASK; end
        end else if (o == BR) begin
            a = 2'b10; alu = 3'b110; pc = taken;
        end
        e = {pc, adr, mw, ir, rw, rs, a, b, imm_of(o), alu, ill};
    endtask

    task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp,
                         input logic [16:0] m);
        n_vec++;
        assert ((got & m) === (exp & m))
        else begin
            n_err++;
            $error("FAIL %s observed=%05h expected=%05h mask=%05h", tag, got & m, exp & m, m);
        end
    endtask

    // Runs ncyc cycles of one instruction (ncyc<0: the whole instruction); entered and left at a negedge.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int zmode, input int ncyc);
        logic [16:0] e, m;
        int len;
        op = o; funct3 = f3; funct7b5 = f7;
        len = (ncyc < 0) ? instr_len(o) : ncyc;
        for (int k = 0; k < len; k++) begin
            zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
            #1;
            model(o, f3, f7, zero, k, e, m);
            check($sformatf("op%07b_f3%03b_c%0d", o, f3, k), obs(), e, m);
            @(negedge clk);
        end
    endtask

    task automatic check_reset(input string tag);
        check(tag, obs(), {5'b00000, 2'b10, 2'b00, 2'b10, imm_of(op), 3'b010, 1'b0}, ALL_MASK);
    endtask

    logic [6:0] ops [6];
    logic [16:0] e_ill;

    initial begin
        ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = IA; ops[4] = JAL; ops[5] = BR;
        reset_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
        @(negedge clk);
        #2 check_reset("reset_hold");
        @(negedge clk);
        reset_n = 1'b1;

        run_instr(RT, 3'b000, 1'b1, 2, -1);
        run_instr(LW, 3'b010, 1'b0, 2, -1);
        run_instr(SW, 3'b010, 1'b0, 2, -1);
        run_instr(BR, 3'b000, 1'b0, 1, -1);
        run_instr(BR, 3'b000, 1'b0, 0, -1);
        run_instr(BR, 3'b001, 1'b0, 1, -1);
        run_instr(BR, 3'b001, 1'b0, 0, -1);
        run_instr(IA, 3'b010, 1'b0, 2, -1);
        run_instr(IA, 3'b110, 1'b0, 2, -1);
        run_instr(IA, 3'b111, 1'b0, 2, -1);
        run_instr(IA, 3'b000, 1'b1, 2, -1);
        run_instr(JAL, 3'b000, 1'b0, 0, -1);

        for (int i = 0; i < 60; i++)
            run_instr(ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2, -1);

        // Reset during MEMWRITE must suppress the store.
        run_instr(SW, 3'b010, 1'b0, 0, 3);
        #2 reset_n = 1'b0;
        #1 check_reset("reset_mid_store");
        @(negedge clk);
        reset_n = 1'b1;
        run_instr(RT, 3'b111, 1'b0, 2, -1);

        run_instr(BAD, 3'b000, 1'b0, 2, -1);
        e_ill = {5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1};
        for (int i = 0; i < 10; i++) begin
            zero = 1'($urandom_range(0, 1));
            #1 check($sformatf("illegal_hold_%0d", i), obs(), e_ill, ALU_MASK);
            @(negedge clk);
        end
        #3 reset_n = 1'b0;
        #1 check_reset("reset_from_illegal");
        @(negedge clk);
        reset_n = 1'b1;
        run_instr(LW, 3'b010, 1'b0, 2, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
